// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter
//   Multi-digit BCD up/down counter with enable, synchronous clear and
//   parallel load. It either wraps or saturates at the range limits, which
//   are 0 and 10^DIGITS-1. It is used for display timebases and decimal
//   event tallies.
//
// Parameters
//   DIGITS   : number of BCD digits (1..8)
//   SATURATE : 0 = wrap at the limits, 1 = hold at the limit
//
// Ports
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset (count=0, wrap=0)
//   clr      in   synchronous clear (highest priority)
//   load     in   synchronous parallel load of load_val
//   load_val in   BCD load value, digit 0 in bits [3:0]
//   en       in   count enable (lowest priority)
//   up       in   1 = increment, 0 = decrement (used only when en=1)
//   count    out  registered BCD count, digit 0 in bits [3:0]
//   tc       out  combinational terminal count, for the en of the next stage
//   wrap     out  registered one-cycle pulse on wrap-around
//   load_err out  sticky invalid-load flag (only with the macro below)
//
// Optional feature
//   BCD_UPDOWN_COUNTER_LOAD_CHECK_EN: when defined, a load containing any
//   digit >9 is rejected as a whole and sets the sticky load_err output.
//   load_err is cleared by clr or reset_n. When the macro is not defined,
//   each invalid digit is replaced by 0.
//
// Handshake: none. clr, load and en are level controls sampled on each
// rising edge, with priority clr > load > en.

module bcd_updown_counter #(
    parameter int DIGITS   = 4,
    parameter int SATURATE = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clr,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic                en,
    input  logic                up,
    output logic [4*DIGITS-1:0] count,
    output logic                tc,
    output logic                wrap
`ifdef BCD_UPDOWN_COUNTER_LOAD_CHECK_EN
    ,
    output logic                load_err
`endif
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0] load_clean;   // load_val with each invalid digit zeroed
    logic [W-1:0] count_inc;    // count + 1, BCD ripple
    logic [W-1:0] count_dec;    // count - 1, BCD ripple
    logic         all_nine;
    logic         all_zero;
    logic         at_limit;     // the current en step would cross a limit
`ifdef BCD_UPDOWN_COUNTER_LOAD_CHECK_EN
    logic         load_bad;     // any load_val digit >9
`endif

    always_comb begin
        logic carry;
        logic borrow;
        load_clean = '0;
        count_inc  = count;
        count_dec  = count;
        all_nine   = 1'b1;
        all_zero   = 1'b1;
        carry      = 1'b1;
        borrow     = 1'b1;
`ifdef BCD_UPDOWN_COUNTER_LOAD_CHECK_EN
        load_bad   = 1'b0;
`endif
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] <= 4'd9) begin
                load_clean[4*i +: 4] = load_val[4*i +: 4];
            end
`ifdef BCD_UPDOWN_COUNTER_LOAD_CHECK_EN
            else begin
                load_bad = 1'b1;
            end
`endif
            if (count[4*i +: 4] != 4'd9) all_nine = 1'b0;
            if (count[4*i +: 4] != 4'd0) all_zero = 1'b0;

            // The carry and the borrow stop at the first digit that can absorb
            // them, so the digits above that digit keep their value.
            if (carry) begin
                if (count[4*i +: 4] == 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (count[4*i +: 4] == 4'd0) begin
                    count_dec[4*i +: 4] = 4'd9;
                end else begin
                    count_dec[4*i +: 4] = count[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
        at_limit = up ? all_nine : all_zero;
    end

    // clr and load take priority over counting, so they suppress tc.
    assign tc = en & ~clr & ~load & at_limit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            wrap     <= 1'b0;
`ifdef BCD_UPDOWN_COUNTER_LOAD_CHECK_EN
            load_err <= 1'b0;
`endif
        end else begin
            wrap <= 1'b0;
            if (clr) begin
                count    <= '0;
`ifdef BCD_UPDOWN_COUNTER_LOAD_CHECK_EN
                load_err <= 1'b0;
`endif
            end else if (load) begin
`ifdef BCD_UPDOWN_COUNTER_LOAD_CHECK_EN
                if (load_bad) begin
                    load_err <= 1'b1;
                end else begin
                    count <= load_clean;
                end
`else
                count <= load_clean;
`endif
            end else if (en) begin
                // At a limit, the ripple result is already the wrapped value
                // (all 9s -> 0 and 0 -> all 9s), so saturation only has to
                // block the update.
                if (!(at_limit && SATURATE != 0)) begin
                    count <= up ? count_inc : count_dec;
                end
                wrap <= at_limit && (SATURATE == 0);
            end
        end
    end

endmodule
